pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h0000_0080, PC value loaded on a misalignment trap.
REQ-003 SHALL have ports: clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 fetch_ready  input  1  instruction memory accepts the current pc this cycle.
REQ-006 stall  input  1  pipeline hazard; freeze pc.
REQ-007 br_req  input  1  taken conditional branch.
REQ-008 br_offset  input  32  sign-extended word offset.
REQ-009 j_req  input  1  absolute jump.
REQ-010 j_target  input  26  jump index field.
REQ-011 jr_req  input  1  register jump.
REQ-012 jr_addr  input  32  register target.
REQ-013 pc  output  32  current fetch address.
REQ-014 pc_plus4  output  32  pc + 4, combinational from pc.
REQ-015 flush  output  1  one-cycle pulse when a redirect is applied.
REQ-016 busy  output  1  high while a redirect is pending.

Function
REQ-017 Advance condition: adv = fetch_ready & ~stall.
REQ-018 Branch target SHALL be pc_plus4 + (br_offset shifted left 2); jump target {pc_plus4[31:28], j_target, 2'b00}; jr target jr_addr.
REQ-019 Priority for simultaneous requests: jr_req > j_req > br_req.
REQ-020 States: RUN, PENDING; reset enters RUN.
REQ-021 RUN, adv=1, request present: pc <= selected target next edge, flush=1 that cycle.
REQ-022 RUN, adv=1, no request: pc <= pc_plus4, flush=0.
REQ-023 RUN, adv=0, request present: capture target into pending register, go to PENDING, pc held.
REQ-024 RUN, adv=0, no request: pc held.
REQ-025 PENDING: busy=1; new requests ignored (first redirect wins); when adv=1, pc <= pending target, flush=1, return to RUN.
REQ-026 Arithmetic is modulo 2^32; pc wraps 32'hFFFF_FFFC -> 32'h0000_0000 without error.
REQ-027 Redirect latency: one cycle from request (with adv=1) to new pc.

Reset
REQ-028 rst_n low SHALL asynchronously force pc=RESET_VECTOR, state=RUN, pending register=0, flush=0, busy=0.
REQ-029 Reset asserted in PENDING SHALL discard the pending redirect.
REQ-030 First advance after rst_n deasserts SHALL fetch RESET_VECTOR.

Configuration
REQ-031 Macro PC_MISALIGN_TRAP_EN: when defined, a selected target with bits [1:0] != 0 SHALL redirect to EXC_VECTOR instead and pulse output misalign (1 bit, same cycle as flush).
REQ-032 Without PC_MISALIGN_TRAP_EN: no misalign port; target bits [1:0] forced to 0.

Structure
REQ-033 State encoding and vector defaults SHALL live in the shared processor package.
REQ-034 Offset scaling SHALL instantiate the existing shift-left-by-2 unit (shift_2) as the one sub-module.

Verification
REQ-035 Reset, adv=1 for 3 cycles -> pc 0x0, 0x4, 0x8, 0xC; flush=0.
REQ-036 pc=0x100, br_req, br_offset=0xFFFF_FFFE, adv=1 -> next pc 0x0FC, flush=1 one cycle.
REQ-037 pc=0x2000_0010, j_req, j_target=0x000_0040, stall=1 for 2 cycles -> busy=1, pc held; stall drop -> pc 0x2000_0100, flush=1.
REQ-038 jr_req (0x400) and br_req same cycle, adv=1 -> pc 0x400; PENDING with second request -> second ignored.
REQ-039 pc=0xFFFF_FFFC, adv=1 -> pc 0x0000_0000.
REQ-040 With PC_MISALIGN_TRAP_EN, jr_addr=0x402 -> pc 0x80, misalign=1; without -> pc 0x400.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared processor package: sequencer state encoding and default PC vectors.
package pc_sequencer_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    PENDING = 1'b1
  } seq_state_t;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/pc_sequencer_shift_2.sv
// Shift-left-by-2 unit: scales a word offset to a byte offset (modulo 2^32).
module shift_2 (
  input  logic [31:0] in,
  output logic [31:0] out
);

  assign out = in << 2;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with branch/jump/register-jump redirect and a
// one-entry pending redirect. Optional macro PC_MISALIGN_TRAP_EN adds a trap.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_ready,
  input  logic        stall,
  input  logic        br_req,
  input  logic [31:0] br_offset,
  input  logic        j_req,
  input  logic [25:0] j_target,
  input  logic        jr_req,
  input  logic [31:0] jr_addr,
`ifdef PC_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic        busy
);

  seq_state_t  state, state_nx;
  logic [31:0] pend, pend_nx;
  logic [31:0] pc_nx;
  logic [31:0] off_sh;
  logic [31:0] sel_tgt, raw_tgt, tgt;
  logic        adv, req, redirect, mis;

  shift_2 u_shift_2 (
    .in  (br_offset),
    .out (off_sh)
  );

  assign pc_plus4 = pc + 32'd4;
  assign adv      = fetch_ready & ~stall;
  assign req      = jr_req | j_req | br_req;
  assign redirect = adv & ((state == PENDING) | req);

  // Target is resolved from the pending register while PENDING so later
  // requests cannot override the first captured redirect.
  always_comb begin
    sel_tgt = '0;
    if (jr_req)      sel_tgt = jr_addr;
    else if (j_req)  sel_tgt = {pc_plus4[31:28], j_target, 2'b00};
    else             sel_tgt = pc_plus4 + off_sh;
    raw_tgt = (state == PENDING) ? pend : sel_tgt;
`ifdef PC_MISALIGN_TRAP_EN
    mis = |raw_tgt[1:0];
    tgt = mis ? EXC_VECTOR : raw_tgt;
`else
    mis = 1'b0;
    tgt = raw_tgt & 32'hFFFF_FFFC;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pc    <= RESET_VECTOR;
      pend  <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      pend  <= pend_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    pend_nx  = pend;
    unique case (state)
      RUN: begin
        if (adv) begin
          pc_nx = req ? tgt : pc_plus4;
        end else if (req) begin
          pend_nx  = sel_tgt;
          state_nx = PENDING;
        end
      end
      PENDING: begin
        if (adv) begin
          pc_nx    = tgt;
          state_nx = RUN;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_comb begin
    flush = rst_n & redirect;
    busy  = (state == PENDING);
`ifdef PC_MISALIGN_TRAP_EN
    misalign = rst_n & redirect & mis;
`endif
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default vectors).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_ready, stall;
  logic        br_req, j_req, jr_req;
  logic [31:0] br_offset, jr_addr;
  logic [25:0] j_target;
  logic [31:0] pc, pc_plus4;
  logic        flush, busy;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_VECTOR (32'h0000_0000),
    .EXC_VECTOR   (32'h0000_0080)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_ready (fetch_ready),
    .stall       (stall),
    .br_req      (br_req),
    .br_offset   (br_offset),
    .j_req       (j_req),
    .j_target    (j_target),
    .jr_req      (jr_req),
    .jr_addr     (jr_addr),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign    (misalign),
`endif
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .flush       (flush),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req();
    br_req = 1'b0; j_req = 1'b0; jr_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; fetch_ready = 1'b1; stall = 1'b0;
    br_req = 1'b0; j_req = 1'b0; jr_req = 1'b0;
    br_offset = '0; jr_addr = '0; j_target = '0;

    // reset held across an edge with adv=1
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h4);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    rst_n = 1'b1;

    tick(); chk("seq_4", pc, 32'h4);
    tick(); chk("seq_8", pc, 32'h8);
    tick(); chk("seq_c", pc, 32'hC);
    chk("seq_flush", {31'b0, flush}, 32'h0);

    // jr to 0x100
    jr_req = 1'b1; jr_addr = 32'h100; #1;
    chk("jr_flush", {31'b0, flush}, 32'h1);
    tick(); clr_req(); chk("jr_pc", pc, 32'h100);

    // backward branch: 0x104 - 8
    br_req = 1'b1; br_offset = 32'hFFFF_FFFE; #1;
    chk("br_flush", {31'b0, flush}, 32'h1);
    tick(); clr_req(); chk("br_pc", pc, 32'h0FC);
    #1 chk("br_flush_end", {31'b0, flush}, 32'h0);

    // jump under stall
    jr_req = 1'b1; jr_addr = 32'h2000_0010;
    tick(); clr_req(); chk("jr2_pc", pc, 32'h2000_0010);
    j_req = 1'b1; j_target = 26'h40; stall = 1'b1; #1;
    chk("j_stall_flush", {31'b0, flush}, 32'h0);
    tick(); clr_req();
    chk("j_stall_pc1", pc, 32'h2000_0010);
    chk("j_stall_busy1", {31'b0, busy}, 32'h1);
    tick();
    chk("j_stall_pc2", pc, 32'h2000_0010);
    chk("j_stall_busy2", {31'b0, busy}, 32'h1);
    stall = 1'b0; #1;
    chk("j_rel_flush", {31'b0, flush}, 32'h1);
    tick();
    chk("j_pc", pc, 32'h2000_0100);
    chk("j_busy", {31'b0, busy}, 32'h0);

    // jr beats br in same cycle
    jr_req = 1'b1; jr_addr = 32'h400; br_req = 1'b1; br_offset = 32'h4;
    tick(); clr_req(); chk("prio_pc", pc, 32'h400);

    // pending: first redirect wins
    stall = 1'b1; jr_req = 1'b1; jr_addr = 32'h800;
    tick(); chk("pend_pc", pc, 32'h400);
    chk("pend_busy", {31'b0, busy}, 32'h1);
    jr_addr = 32'hC00; j_req = 1'b1;
    tick(); clr_req(); chk("pend_hold", pc, 32'h400);
    stall = 1'b0;
    tick(); chk("pend_pc2", pc, 32'h800);

    // reset while pending discards the redirect
    stall = 1'b1; br_req = 1'b1; br_offset = 32'h10;
    tick(); clr_req(); chk("rp_busy", {31'b0, busy}, 32'h1);
    #2 rst_n = 1'b0; #1;
    chk("rp_pc", pc, 32'h0);
    chk("rp_busy0", {31'b0, busy}, 32'h0);
    #1 rst_n = 1'b1; stall = 1'b0;
    tick(); chk("rp_after", pc, 32'h4);

    // wrap at top of address space
    jr_req = 1'b1; jr_addr = 32'hFFFF_FFFC;
    tick(); clr_req(); chk("wrap_pre", pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4, 32'h0);
    tick(); chk("wrap_pc", pc, 32'h0);

    // fetch not ready: pc holds
    fetch_ready = 1'b0;
    tick(); chk("hold_pc", pc, 32'h0);
    fetch_ready = 1'b1;

    // misaligned register target
    jr_req = 1'b1; jr_addr = 32'h402; #1;
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_pulse", {31'b0, misalign}, 32'h1);
    tick(); clr_req(); chk("mis_pc", pc, 32'h80);
`else
    chk("mis_flush", {31'b0, flush}, 32'h1);
    tick(); clr_req(); chk("mis_pc", pc, 32'h400);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
